pll_ctrl: RTL

Sequencing controller for the on-chip rPLL. It holds the PLL in reset after power-up and waits for a qualified lock. On loss of lock it re-runs the lock sequence, and after repeated lock timeouts it powers the PLL down and flags failure. It also arbitrates dynamic phase (PSDA) and duty (DUTYDA) updates and provides a `ready` qualifier that downstream logic synchronizes into the PLL output domain. It runs on the PLL reference clock, next to the PLL wrapper in the clocking top.

---
 rtl/pll_ctrl_pkg.sv | 28 ++
 rtl/pll_ctrl_if.sv | 10 +
 rtl/pll_lock_filter.sv | 58 +++++
 rtl/pll_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the rPLL sequencing controller.
// The CFG state exists only when PLLCTRL_DYNCFG_EN is defined.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_FILTER = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
`ifdef PLLCTRL_DYNCFG_EN
    , ST_CFG  = 3'd5
`endif
  } pll_state_e;

  localparam logic [3:0] PSDA_DEFAULT   = 4'b0000;
  localparam logic [3:0] DUTYDA_DEFAULT = 4'b1000;
  localparam int         RELOCK_W       = 8;

  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    if (v == {RELOCK_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(RELOCK_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/pll_ctrl_if.sv
// Dynamic phase/duty configuration handshake between a requester and pll_ctrl.
interface pll_ctrl_if;
  logic       cfg_req;
  logic [3:0] cfg_psda;
  logic [3:0] cfg_dutyda;
  logic       cfg_ack;

  modport master (output cfg_req, cfg_psda, cfg_dutyda, input cfg_ack);
  modport slave  (input cfg_req, cfg_psda, cfg_dutyda, output cfg_ack);
endinterface

// File: rtl/pll_lock_filter.sv
// Two-flop synchronizer for PLL LOCK plus a consecutive-high qualification counter.
module pll_lock_filter #(
  parameter int LOCK_FILT = 1024
) (
  input  logic clkin,
  input  logic resetn,
  input  logic en,
  input  logic pll_lock,
  output logic lk,
  output logic qualified
);
  localparam int FW = $clog2(LOCK_FILT + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [FW-1:0] cnt_r;
  logic [FW-1:0] cnt_next_s;
  logic          qual_r;

  // Synchronize the asynchronous lock indication into clkin
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pll_lock;
      sync2_r <= sync1_r;
    end
  end

  // Saturating run-length of synced lock while the search is active
  always_comb begin
    cnt_next_s = '0;
    if (en && sync2_r) begin
      if (cnt_r == FW'(LOCK_FILT)) begin
        cnt_next_s = cnt_r;
      end else begin
        cnt_next_s = cnt_r + FW'(1);
      end
    end else begin
      cnt_next_s = '0;
    end
  end

  // Counter and qualified flag registers
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      cnt_r  <= '0;
      qual_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      qual_r <= (cnt_next_s == FW'(LOCK_FILT));
    end
  end

  assign lk        = sync2_r;
  assign qualified = qual_r;
endmodule

// File: rtl/pll_ctrl.sv
// rPLL sequencing controller: reset/lock sequencing, retry/fail, relock counting.
// Dynamic PSDA/DUTYDA updates through the CFG state are enabled by PLLCTRL_DYNCFG_EN.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_FILT    = 1024,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int MAX_RETRY    = 3,
  parameter int SETTLE       = 16
) (
  input  logic                clkin,
  input  logic                resetn,
  input  logic                pll_lock,
  output logic                pll_reset,
  output logic                pll_reset_p,
  output logic [3:0]          pll_psda,
  output logic [3:0]          pll_dutyda,
  output logic                ready,
  output logic                fail,
  output logic [RELOCK_W-1:0] relock_cnt,
  pll_ctrl_if.slave           cfg
);
  localparam int CNT_LIM = (LOCK_TIMEOUT > RST_CYCLES)
                         ? ((LOCK_TIMEOUT > SETTLE + 1) ? LOCK_TIMEOUT : SETTLE + 1)
                         : ((RST_CYCLES > SETTLE + 1) ? RST_CYCLES : SETTLE + 1);
  localparam int CW = $clog2(CNT_LIM + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  pll_state_e          state_r, next_s;
  logic [CW-1:0]       cnt_r;
  logic [RW-1:0]       retry_r;
  logic                lk_s, qual_s, filt_en_s, cnt_run_s;
  logic                retry_inc_s, retry_clr_s, relock_inc_s;
  logic                pll_reset_r, pll_reset_p_r, fail_r, ready_r, cfg_ack_r;
  logic [3:0]          psda_r, duty_r;
  logic [RELOCK_W-1:0] relock_r;
`ifdef PLLCTRL_DYNCFG_EN
  logic                ack_s;
`else
  logic                req_d_r;
`endif

  assign filt_en_s = (state_r == ST_SEARCH) || (state_r == ST_FILTER);

  pll_lock_filter #(.LOCK_FILT(LOCK_FILT)) u_filt (
    .clkin(clkin), .resetn(resetn), .en(filt_en_s), .pll_lock(pll_lock),
    .lk(lk_s), .qualified(qual_s)
  );

  // Next-state and event decode
  always_comb begin
    next_s       = state_r;
    retry_inc_s  = 1'b0;
    retry_clr_s  = 1'b0;
    relock_inc_s = 1'b0;
    cnt_run_s    = (state_r == ST_HOLD) || (state_r == ST_SEARCH);
`ifdef PLLCTRL_DYNCFG_EN
    ack_s        = 1'b0;
    cnt_run_s    = cnt_run_s || (state_r == ST_CFG);
`endif
    case (state_r)
      ST_HOLD: begin
        if (cnt_r == CW'(RST_CYCLES - 1)) next_s = ST_SEARCH;
        else                              next_s = ST_HOLD;
      end
      ST_SEARCH: begin
        if (lk_s) begin
          next_s = ST_FILTER;
        end else if (cnt_r == CW'(LOCK_TIMEOUT - 1)) begin
          retry_inc_s = 1'b1;
          if (retry_r + RW'(1) == RW'(MAX_RETRY)) next_s = ST_FAIL;
          else                                    next_s = ST_HOLD;
        end else begin
          next_s = ST_SEARCH;
        end
      end
      ST_FILTER: begin
        if (!lk_s) begin
          next_s = ST_SEARCH;
        end else if (qual_s) begin
          next_s      = ST_RUN;
          retry_clr_s = 1'b1;
        end else begin
          next_s = ST_FILTER;
        end
      end
      ST_RUN: begin
        if (!lk_s) begin
          next_s       = ST_HOLD;
          relock_inc_s = 1'b1;
`ifdef PLLCTRL_DYNCFG_EN
        end else if (cfg.cfg_req && !cfg_ack_r) begin
          // the ack cycle itself is spent in RUN so a lingering request is not re-serviced
          next_s = ST_CFG;
`endif
        end else begin
          next_s = ST_RUN;
        end
      end
`ifdef PLLCTRL_DYNCFG_EN
      ST_CFG: begin
        if (!lk_s) begin
          next_s       = ST_HOLD;
          relock_inc_s = 1'b1;
        end else if (cnt_r == CW'(SETTLE)) begin
          next_s = ST_RUN;
          ack_s  = 1'b1;
        end else begin
          next_s = ST_CFG;
        end
      end
`endif
      ST_FAIL: next_s = ST_FAIL;
      default: next_s = ST_HOLD;
    endcase
  end

  // State, per-state counter and retry counter
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_HOLD;
      cnt_r   <= '0;
      retry_r <= '0;
    end else begin
      state_r <= next_s;
      if (next_s != state_r) cnt_r <= '0;
      else if (cnt_run_s)    cnt_r <= cnt_r + CW'(1);
      else                   cnt_r <= '0;
      if (retry_clr_s)      retry_r <= '0;
      else if (retry_inc_s) retry_r <= retry_r + RW'(1);
      else                  retry_r <= retry_r;
    end
  end

  // Registered outputs derived from the upcoming state
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      pll_reset_r   <= 1'b1;
      pll_reset_p_r <= 1'b0;
      fail_r        <= 1'b0;
      ready_r       <= 1'b0;
      cfg_ack_r     <= 1'b0;
      psda_r        <= PSDA_DEFAULT;
      duty_r        <= DUTYDA_DEFAULT;
      relock_r      <= '0;
`ifndef PLLCTRL_DYNCFG_EN
      req_d_r       <= 1'b0;
`endif
    end else begin
      pll_reset_r   <= (next_s == ST_HOLD) || (next_s == ST_FAIL);
      pll_reset_p_r <= (next_s == ST_FAIL);
      fail_r        <= (next_s == ST_FAIL);
      if (relock_inc_s) relock_r <= sat_inc(relock_r);
      else              relock_r <= relock_r;
`ifdef PLLCTRL_DYNCFG_EN
      ready_r   <= (next_s == ST_RUN) || (next_s == ST_CFG);
      cfg_ack_r <= ack_s;
      if (state_r == ST_CFG && cnt_r == '0) begin
        psda_r <= cfg.cfg_psda;
        duty_r <= cfg.cfg_dutyda;
      end else begin
        psda_r <= psda_r;
        duty_r <= duty_r;
      end
`else
      // without dynamic config, acknowledge every request edge so requesters never stall
      ready_r   <= (next_s == ST_RUN);
      cfg_ack_r <= cfg.cfg_req && !req_d_r;
      req_d_r   <= cfg.cfg_req;
      psda_r    <= PSDA_DEFAULT;
      duty_r    <= DUTYDA_DEFAULT;
`endif
    end
  end

  assign pll_reset   = pll_reset_r;
  assign pll_reset_p = pll_reset_p_r;
  assign fail        = fail_r;
  assign ready       = ready_r;
  assign relock_cnt  = relock_r;
  assign pll_psda    = psda_r;
  assign pll_dutyda  = duty_r;
  assign cfg.cfg_ack = cfg_ack_r;
endmodule
